acc_cpu_param: RTL and testbench



---
 rtl/acc_cpu_pkg.sv | 54 +++++
 rtl/acc_cpu_alu.sv | 40 ++++
 rtl/acc_cpu_param.sv | 131 +++++++++++++
 tb/tb_acc_cpu_param.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared opcodes, FSM states and ALU selects for the accumulator CPU.
// Imported by acc_cpu_alu and acc_cpu_param.
package acc_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDM  = 4'h2;
    localparam logic [3:0] OP_STA  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_ADDM = 4'h5;
    localparam logic [3:0] OP_SUBI = 4'h6;
    localparam logic [3:0] OP_SUBM = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BRZ  = 4'h9;
    localparam logic [3:0] OP_BRC  = 4'hA;
    localparam logic [3:0] OP_BRN  = 4'hB;
    localparam logic [3:0] OP_ANDI = 4'hC;
    localparam logic [3:0] OP_ORI  = 4'hD;
    localparam logic [3:0] OP_XORI = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR
    } alu_op_t;

    function automatic alu_op_t alu_sel(input logic [3:0] op);
        case (op)
            OP_ADDI, OP_ADDM: return ALU_ADD;
            OP_SUBI, OP_SUBM: return ALU_SUB;
            OP_ANDI:          return ALU_AND;
            OP_ORI:           return ALU_OR;
            OP_XORI:          return ALU_XOR;
            default:          return ALU_PASS;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDM) || (op == OP_STA) ||
               (op == OP_ADDM) || (op == OP_SUBM);
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: pass/add/sub/and/or/xor, modular over DATA_W.
// c is carry-out for add and borrow for sub.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] y,
    output logic              c
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        y    = b;
        c    = 1'b0;
        unique case (op)
            ALU_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                y    = wide[DATA_W-1:0];
                c    = wide[DATA_W];
            end
            ALU_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                y    = wide[DATA_W-1:0];
                c    = wide[DATA_W];
            end
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_PASS: y = b;
            default:  y = b;
        endcase
    end

endmodule

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU, multi-cycle FSM over one req/ready memory port.
// Define TOYCPU_SCAN_EN to add the scan_en/scan_out state-capture chain.
module acc_cpu_param
    import acc_cpu_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W+3:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] acc_out,
    output logic [2:0]        flags,
    output logic              halted
`ifdef TOYCPU_SCAN_EN
    ,
    input  logic              scan_en,
    output logic              scan_out
`endif
);

    state_t              state;
    logic [DATA_W+3:0]   ir;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   acc;
    logic                fc, fz, fn;

    logic [3:0]          op;
    logic [DATA_W-1:0]   opd;
    logic [ADDR_W-1:0]   a;
    alu_op_t             alu_op;
    logic [DATA_W-1:0]   alu_b, alu_y;
    logic                alu_c;
    logic                acc_we, c_we, take;

    assign op     = ir[DATA_W+3:DATA_W];
    assign opd    = ir[DATA_W-1:0];
    assign a      = opd[ADDR_W-1:0];
    assign alu_op = alu_sel(op);
    assign alu_b  = (state == ST_MEM) ? mem_rdata[DATA_W-1:0] : opd;

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a  (acc),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y),
        .c  (alu_c)
    );

    always_comb begin
        acc_we = 1'b0;
        unique case (state)
            ST_EXEC: acc_we = op inside {OP_LDI, OP_ADDI, OP_SUBI,
                                         OP_ANDI, OP_ORI, OP_XORI};
            ST_MEM:  acc_we = mem_ready &&
                              (op inside {OP_LDM, OP_ADDM, OP_SUBM});
            default: acc_we = 1'b0;
        endcase
    end

    assign c_we = acc_we && (alu_op == ALU_ADD || alu_op == ALU_SUB);
    assign take = (op == OP_BRZ && fz) || (op == OP_BRC && fc) ||
                  (op == OP_BRN && fn);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            acc   <= '0;
            fc    <= 1'b0;
            fz    <= 1'b0;
            fn    <= 1'b0;
        end else begin
            unique case (state)
                ST_FETCH: if (run && mem_ready) begin
                    ir    <= mem_rdata;
                    pc    <= pc + ADDR_W'(1);
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_mem_op(op))    state <= ST_MEM;
                    else if (op == OP_HLT) state <= ST_HALT;
                    else                  state <= ST_FETCH;
                    // pc already points past this instruction
                    if (op == OP_JMP) pc <= a;
                    else if (take)    pc <= pc + a;
                end
                ST_MEM:  if (mem_ready) state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
            if (acc_we) begin
                acc <= alu_y;
                fz  <= (alu_y == '0);
                fn  <= alu_y[DATA_W-1];
                if (c_we) fc <= alu_c;
            end
        end
    end

    assign mem_req   = rst_n && ((state == ST_FETCH && run) ||
                                 state == ST_MEM);
    assign mem_we    = (state == ST_MEM) && (op == OP_STA);
    assign mem_addr  = (state == ST_MEM) ? a : pc;
    assign mem_wdata = acc;
    assign acc_out   = acc;
    assign flags     = {fc, fz, fn};
    assign halted    = (state == ST_HALT);

`ifdef TOYCPU_SCAN_EN
    localparam int SCAN_W = 4 + 2 * DATA_W + 3 + ADDR_W;
    logic [SCAN_W-1:0] scan_q;

    always_ff @(posedge clk) begin
        if (!rst_n)       scan_q <= '0;
        else if (scan_en) scan_q <= {scan_q[SCAN_W-2:0], 1'b0};
        else              scan_q <= {ir, acc, fc, fz, fn, pc};
    end

    assign scan_out = scan_q[SCAN_W-1];
`endif

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed bench for acc_cpu_param: vector table of register/branch
// instructions plus hand sequences for memory, wait states, HLT and reset.
module tb_acc_cpu_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [11:0] mem_rdata;
    logic        mem_ready;
    logic [7:0]  acc_out;
    logic [2:0]  flags;
    logic        halted;

    logic [11:0] mem [0:255];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [11:0] instr;
        logic [7:0]  acc;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs [18];

    acc_cpu_param #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .acc_out   (acc_out),
        .flags     (flags),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we)
            mem[mem_addr] = {4'h0, mem_wdata};
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{8'h00, 12'h810, 8'h00, 3'b000};
        vecs[1]  = '{8'h10, 12'h1F0, 8'hF0, 3'b001};
        vecs[2]  = '{8'h11, 12'h420, 8'h10, 3'b100};
        vecs[3]  = '{8'h12, 12'h611, 8'hFF, 3'b101};
        vecs[4]  = '{8'h13, 12'hEFF, 8'h00, 3'b110};
        vecs[5]  = '{8'h14, 12'h805, 8'h00, 3'b110};
        vecs[6]  = '{8'h05, 12'h9FE, 8'h00, 3'b110};
        vecs[7]  = '{8'h04, 12'h820, 8'h00, 3'b110};
        vecs[8]  = '{8'h20, 12'h101, 8'h01, 3'b100};
        vecs[9]  = '{8'h21, 12'h905, 8'h01, 3'b100};
        vecs[10] = '{8'h22, 12'h601, 8'h00, 3'b010};
        vecs[11] = '{8'h23, 12'hA10, 8'h00, 3'b010};
        vecs[12] = '{8'h24, 12'hD80, 8'h80, 3'b001};
        vecs[13] = '{8'h25, 12'hB10, 8'h80, 3'b001};
        vecs[14] = '{8'h36, 12'h880, 8'h80, 3'b001};
        vecs[15] = '{8'h80, 12'h490, 8'h10, 3'b100};
        vecs[16] = '{8'h81, 12'hA02, 8'h10, 3'b100};
        vecs[17] = '{8'h84, 12'h000, 8'h10, 3'b100};

        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
        foreach (vecs[i]) mem[vecs[i].addr] = vecs[i].instr;
        mem[8'h85] = 12'h340;
        mem[8'h86] = 12'h100;
        mem[8'h87] = 12'h240;
        mem[8'h88] = 12'h540;
        mem[8'h89] = 12'hF00;

        rst_n = 1'b0;
        run = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        chk("rst_req", mem_req, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_flags", flags, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", mem_addr, 0);

        rst_n = 1'b1;
        tick();
        chk("pause_req", mem_req, 0);
        tick();
        chk("pause_req2", mem_req, 0);
        run = 1'b1;
        #1;
        chk("run_req", mem_req, 1);

        foreach (vecs[i]) begin
            chk($sformatf("v%0d_fetch_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("v%0d_fetch_rd", i), {mem_req, mem_we}, 2'b10);
            tick();
            tick();
            chk($sformatf("v%0d_acc", i), acc_out, vecs[i].acc);
            chk($sformatf("v%0d_flags", i), flags, vecs[i].flags);
        end

        chk("sta_fetch", mem_addr, 8'h85);
        tick();
        mem_ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sta_wait%0d_ctl", k), {mem_req, mem_we}, 2'b11);
            chk($sformatf("sta_wait%0d_addr", k), mem_addr, 8'h40);
            chk($sformatf("sta_wait%0d_wdata", k), mem_wdata, 8'h10);
            chk($sformatf("sta_wait%0d_nowr", k), mem[8'h40], 0);
            tick();
        end
        chk("sta_last_addr", mem_addr, 8'h40);
        mem_ready = 1'b1;
        tick();
        chk("sta_written", mem[8'h40], 12'h010);
        chk("sta_6cyc_fetch", mem_addr, 8'h86);
        chk("sta_6cyc_rd", {mem_req, mem_we}, 2'b10);

        tick();
        tick();
        chk("ldi0_acc", acc_out, 0);
        chk("ldi0_flags", flags, 3'b110);
        tick();
        tick();
        tick();
        chk("ldm_acc", acc_out, 8'h10);
        chk("ldm_flags", flags, 3'b100);
        tick();
        tick();
        tick();
        chk("addm_acc", acc_out, 8'h20);
        chk("addm_flags", flags, 3'b000);

        tick();
        tick();
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("hlt%0d_halted", k), halted, 1);
            chk($sformatf("hlt%0d_req", k), mem_req, 0);
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("hlt_rst_halted", halted, 0);
        chk("hlt_rst_req", mem_req, 0);

        mem[8'h00] = 12'h341;
        mem[8'h41] = 12'h05A;
        rst_n = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("mrst_mem_ctl", {mem_req, mem_we}, 2'b11);
        chk("mrst_mem_addr", mem_addr, 8'h41);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("mrst_req_low", mem_req, 0);
        tick();
        chk("mrst_no_write", mem[8'h41], 12'h05A);
        chk("mrst_req_held", mem_req, 0);
        rst_n = 1'b1;
        run = 1'b0;
        #1;
        chk("mrst_paused", mem_req, 0);
        run = 1'b1;
        #1;
        chk("mrst_refetch_req", mem_req, 1);
        chk("mrst_pc", mem_addr, 0);
        chk("mrst_acc", acc_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
